// File: rtl/preamble_sequencer.sv
// rtl/preamble_sequencer.sv - PPDU prefix sequencer: streams STF, LTF and SIGNAL symbols over valid/ready.
// The SIGNAL word is built once when a request is accepted; symbols are selected from state and index.
module preamble_sequencer #(
    parameter int SYM_W = 4,
    parameter int N_STF = 10,
    parameter int N_LTF = 2,
    parameter logic [N_STF*SYM_W-1:0] STF_SEQ = 40'h0086E3B5D1,
    parameter logic [N_LTF*SYM_W-1:0] LTF_SEQ = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [3:0]       rate_i,
    input  logic [11:0]      length_i,
    output logic [SYM_W-1:0] sym_o,
    output logic [1:0]       sym_type_o,
    output logic             last_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int N_SIG   = 24 / SYM_W;
    localparam int MAX_TL  = (N_STF > N_LTF) ? N_STF : N_LTF;
    localparam int IDX_MAX = (MAX_TL > N_SIG) ? MAX_TL : N_SIG;
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STF  = 2'd1,
        LTF  = 2'd2,
        SIG  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [23:0]      sig_q, sig_d;
    logic             done_d, err_d;
    logic             handshake;

    // Bit 0 goes out first: rate, reserved, length, even parity, zero tail.
    function automatic logic [23:0] build_sig(input logic [3:0] rate, input logic [11:0] length);
        logic parity;
        parity = ^{length, rate};
        return {6'b0, parity, length, 1'b0, rate};
    endfunction

    assign handshake = valid_o && ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sig_q   <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sig_q   <= sig_d;
            done_o  <= done_d;
            err_o   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sig_d   = sig_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (length_i != 12'd0) begin
                        sig_d   = build_sig(rate_i, length_i);
                        idx_d   = '0;
                        state_d = STF;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STF: begin
                if (handshake) begin
                    if (idx_q == IDX_W'(N_STF - 1)) begin
                        idx_d   = '0;
                        state_d = LTF;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LTF: begin
                if (handshake) begin
                    if (idx_q == IDX_W'(N_LTF - 1)) begin
                        idx_d   = '0;
                        state_d = SIG;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SIG: begin
                if (handshake) begin
                    if (idx_q == IDX_W'(N_SIG - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs depend only on registered state, so they hold during stalls.
    always_comb begin
        sym_o      = '0;
        sym_type_o = 2'd0;
        last_o     = 1'b0;
        valid_o    = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            STF: begin
                sym_o      = SYM_W'(STF_SEQ >> (SYM_W * int'(idx_q)));
                sym_type_o = 2'd0;
                valid_o    = 1'b1;
                busy_o     = 1'b1;
            end
            LTF: begin
                sym_o      = SYM_W'(LTF_SEQ >> (SYM_W * int'(idx_q)));
                sym_type_o = 2'd1;
                valid_o    = 1'b1;
                busy_o     = 1'b1;
            end
            SIG: begin
                sym_o      = SYM_W'(sig_q >> (SYM_W * int'(idx_q)));
                sym_type_o = 2'd2;
                last_o     = (idx_q == IDX_W'(N_SIG - 1));
                valid_o    = 1'b1;
                busy_o     = 1'b1;
            end
            default: begin
                sym_o = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_preamble_sequencer.sv
// tb/tb_preamble_sequencer.sv - self-checking bench for preamble_sequencer (default and 8-bit-symbol instances).
module tb_preamble_sequencer;

    localparam logic [39:0] STF_A = 40'h0086E3B5D1;
    localparam logic [7:0]  LTF_A = 8'h00;
    localparam logic [31:0] STF_B = 32'hA1B2C3D4;
    localparam logic [7:0]  LTF_B = 8'h5E;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, ready;
    logic [3:0]  rate;
    logic [11:0] length;

    logic [3:0] sym_a;
    logic [1:0] type_a;
    logic       last_a, valid_a, busy_a, done_a, err_a;
    logic [7:0] sym_b;
    logic [1:0] type_b;
    logic       last_b, valid_b, busy_b, done_b, err_b;

    preamble_sequencer dut_a (
        .clk(clk), .rst(rst), .start_i(start), .rate_i(rate), .length_i(length),
        .sym_o(sym_a), .sym_type_o(type_a), .last_o(last_a), .valid_o(valid_a),
        .ready_i(ready), .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    preamble_sequencer #(
        .SYM_W(8), .N_STF(4), .N_LTF(1), .STF_SEQ(STF_B), .LTF_SEQ(LTF_B)
    ) dut_b (
        .clk(clk), .rst(rst), .start_i(start), .rate_i(rate), .length_i(length),
        .sym_o(sym_b), .sym_type_o(type_b), .last_o(last_b), .valid_o(valid_b),
        .ready_i(ready), .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int exp_a[$], ety_a[$], exp_b[$], ety_b[$];
    int n_got_a, n_got_b, done_cnt_a, done_cnt_b, done_cyc_a, done_cyc_b, hs_a, hs_b;

    function automatic int sig_model(input int r, input int l);
        int p;
        p = ($countones(r) + $countones(l)) % 2;
        return r + l * 32 + p * 131072;
    endfunction

    task automatic fill_expected(input int r, input int l);
        int s;
        s = sig_model(r, l);
        exp_a = {}; ety_a = {}; exp_b = {}; ety_b = {};
        for (int i = 0; i < 10; i++) begin exp_a.push_back(int'((STF_A >> (4 * i)) & 40'hF)); ety_a.push_back(0); end
        for (int i = 0; i < 2; i++)  begin exp_a.push_back(int'((LTF_A >> (4 * i)) & 8'hF));  ety_a.push_back(1); end
        for (int k = 0; k < 6; k++)  begin exp_a.push_back((s >> (4 * k)) % 16);              ety_a.push_back(2); end
        for (int i = 0; i < 4; i++)  begin exp_b.push_back(int'((STF_B >> (8 * i)) & 32'hFF)); ety_b.push_back(0); end
        exp_b.push_back(int'(LTF_B)); ety_b.push_back(1);
        for (int k = 0; k < 3; k++)  begin exp_b.push_back((s >> (8 * k)) % 256);             ety_b.push_back(2); end
    endtask

    task automatic launch(input logic [3:0] r, input logic [11:0] l);
        fill_expected(int'(r), int'(l));
        @(negedge clk);
        start = 1'b1; rate = r; length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitors both instances cycle by cycle, scoring each handshake against the expected queues.
    task automatic collect(input int stall_pct, input int inject_cyc, input int max_cyc);
        logic st_a, st_b, pl_a, pl_b;
        logic [3:0] ps_a;
        logic [7:0] ps_b;
        logic [1:0] pt_a, pt_b;
        st_a = 1'b0; st_b = 1'b0; pl_a = 1'b0; pl_b = 1'b0;
        ps_a = '0; ps_b = '0; pt_a = '0; pt_b = '0;
        n_got_a = 0; n_got_b = 0; done_cnt_a = 0; done_cnt_b = 0;
        done_cyc_a = -10; done_cyc_b = -10; hs_a = -1; hs_b = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            start = (c == inject_cyc);
            if (c == inject_cyc) begin rate = 4'hF; length = 12'd4095; end
            if (st_a) begin
                n_checks++;
                if (valid_a !== 1'b1 || sym_a !== ps_a || type_a !== pt_a || last_a !== pl_a) begin
                    n_fail++;
                    $display("FAIL stall_hold_a cyc %0d: got v=%b sym=%h type=%0d last=%b, required v=1 sym=%h type=%0d last=%b",
                             c, valid_a, sym_a, type_a, last_a, ps_a, pt_a, pl_a);
                end
            end
            if (st_b) begin
                n_checks++;
                if (valid_b !== 1'b1 || sym_b !== ps_b || type_b !== pt_b || last_b !== pl_b) begin
                    n_fail++;
                    $display("FAIL stall_hold_b cyc %0d: got v=%b sym=%h type=%0d last=%b, required v=1 sym=%h type=%0d last=%b",
                             c, valid_b, sym_b, type_b, last_b, ps_b, pt_b, pl_b);
                end
            end
            if (done_cnt_a == 0 && n_got_a > 0 && n_got_a < exp_a.size()) begin
                n_checks++;
                if (valid_a !== 1'b1 || busy_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL valid_busy_a cyc %0d: got valid=%b busy=%b, required 1 1", c, valid_a, busy_a);
                end
            end
            if (done_cnt_a > 0) begin
                n_checks++;
                if (valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_done_a cyc %0d: got valid=%b busy=%b done=%b, required 0 0 0", c, valid_a, busy_a, done_a);
                end
            end
            if (done_cnt_b > 0) begin
                n_checks++;
                if (valid_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_done_b cyc %0d: got valid=%b busy=%b done=%b, required 0 0 0", c, valid_b, busy_b, done_b);
                end
            end
            if (done_a === 1'b1) begin
                done_cnt_a++; done_cyc_a = c;
                n_checks++;
                if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_idle_a cyc %0d: got valid=%b busy=%b, required 0 0", c, valid_a, busy_a);
                end
            end
            if (done_b === 1'b1) begin
                done_cnt_b++; done_cyc_b = c;
            end
            if (valid_a === 1'b1 && ready === 1'b1) begin
                n_checks++;
                if (n_got_a >= exp_a.size()) begin
                    n_fail++;
                    $display("FAIL extra_sym_a cyc %0d: got symbol %0d, required at most %0d", c, n_got_a + 1, exp_a.size());
                end else if (sym_a !== exp_a[n_got_a] || type_a !== ety_a[n_got_a] ||
                             last_a !== (n_got_a == exp_a.size() - 1)) begin
                    n_fail++;
                    $display("FAIL sym_a #%0d: got sym=%h type=%0d last=%b, required sym=%h type=%0d last=%b", n_got_a,
                             sym_a, type_a, last_a, exp_a[n_got_a], ety_a[n_got_a], n_got_a == exp_a.size() - 1);
                end
                n_got_a++; hs_a = c;
            end
            if (valid_b === 1'b1 && ready === 1'b1) begin
                n_checks++;
                if (n_got_b >= exp_b.size()) begin
                    n_fail++;
                    $display("FAIL extra_sym_b cyc %0d: got symbol %0d, required at most %0d", c, n_got_b + 1, exp_b.size());
                end else if (sym_b !== exp_b[n_got_b] || type_b !== ety_b[n_got_b] ||
                             last_b !== (n_got_b == exp_b.size() - 1)) begin
                    n_fail++;
                    $display("FAIL sym_b #%0d: got sym=%h type=%0d last=%b, required sym=%h type=%0d last=%b", n_got_b,
                             sym_b, type_b, last_b, exp_b[n_got_b], ety_b[n_got_b], n_got_b == exp_b.size() - 1);
                end
                n_got_b++; hs_b = c;
            end
            st_a = (valid_a === 1'b1 && ready !== 1'b1); ps_a = sym_a; pt_a = type_a; pl_a = last_a;
            st_b = (valid_b === 1'b1 && ready !== 1'b1); ps_b = sym_b; pt_b = type_b; pl_b = last_b;
            if (done_cnt_a > 0 && done_cnt_b > 0 && c >= done_cyc_a + 2 && c >= done_cyc_b + 2) break;
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
    endtask

    task automatic test_packet_totals(input string name);
        n_checks++;
        if (n_got_a != 18 || done_cnt_a != 1 || done_cyc_a != hs_a + 1) begin
            n_fail++;
            $display("FAIL %s totals_a: got syms=%0d dones=%0d done_cyc=%0d last_hs=%0d, required 18 1 last_hs+1",
                     name, n_got_a, done_cnt_a, done_cyc_a, hs_a);
        end
        n_checks++;
        if (n_got_b != 8 || done_cnt_b != 1 || done_cyc_b != hs_b + 1) begin
            n_fail++;
            $display("FAIL %s totals_b: got syms=%0d dones=%0d done_cyc=%0d last_hs=%0d, required 8 1 last_hs+1",
                     name, n_got_b, done_cnt_b, done_cyc_b, hs_b);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; ready = 1'b1; rate = '0; length = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sym_a, type_a, last_a, valid_a, busy_a, done_a, err_a} !== 11'd0 ||
            {sym_b, type_b, last_b, valid_b, busy_b, done_b, err_b} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_values: got a=%h b=%h, required all zero",
                     {sym_a, type_a, last_a, valid_a, busy_a, done_a, err_a},
                     {sym_b, type_b, last_b, valid_b, busy_b, done_b, err_b});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal;
        launch(4'b1011, 12'd100);
        exp_a = '{1, 13, 5, 11, 3, 14, 6, 8, 0, 0, 0, 0, 11, 8, 12, 0, 0, 0};
        collect(0, 0, 400);
        test_packet_totals("nominal");
        n_checks++;
        if (hs_a != 18 || done_cyc_a != 19) begin
            n_fail++;
            $display("FAIL nominal_timing: got last_hs=%0d done=%0d, required 18 19", hs_a, done_cyc_a);
        end
    endtask

    task automatic test_stall;
        launch(4'b1011, 12'd100);
        collect(50, 0, 600);
        test_packet_totals("stall");
    endtask

    task automatic test_zero_length;
        @(negedge clk);
        start = 1'b1; rate = 4'h5; length = 12'd0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (err_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b0 || err_b !== 1'b1 || valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_err: got err=%b valid=%b busy=%b err_b=%b valid_b=%b, required 1 0 0 1 0",
                     err_a, valid_a, busy_a, err_b, valid_b);
        end
        @(negedge clk);
        n_checks++;
        if (err_a !== 1'b0 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_after: got err=%b valid=%b busy=%b, required 0 0 0", err_a, valid_a, busy_a);
        end
    endtask

    task automatic test_ignore_start;
        launch(4'd0, 12'd1);
        exp_a[12] = 0; exp_a[13] = 2; exp_a[14] = 0; exp_a[15] = 0; exp_a[16] = 2; exp_a[17] = 0;
        collect(0, 5, 400);
        test_packet_totals("ignore_start");
    endtask

    task automatic test_mid_reset;
        launch(4'h6, 12'd300);
        repeat (4) begin ready = 1'b1; @(negedge clk); end
        n_checks++;
        if (valid_a !== 1'b1 || sym_a !== 4'h3 || type_a !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset_pos: got valid=%b sym=%h type=%0d, required 1 3 0", valid_a, sym_a, type_a);
        end
        rst = 1'b1; start = 1'b1; rate = 4'h9; length = 12'd7;
        @(negedge clk);
        n_checks++;
        if ({sym_a, type_a, last_a, valid_a, busy_a, done_a, err_a} !== 11'd0 ||
            {sym_b, type_b, last_b, valid_b, busy_b, done_b, err_b} !== 15'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got a=%h b=%h, required all zero",
                     {sym_a, type_a, last_a, valid_a, busy_a, done_a, err_a},
                     {sym_b, type_b, last_b, valid_b, busy_b, done_b, err_b});
        end
        @(negedge clk);
        n_checks++;
        if (valid_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: got valid=%b done=%b busy=%b, required 0 0 0", valid_a, done_a, busy_a);
        end
        fill_expected(9, 7);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        collect(0, 0, 400);
        test_packet_totals("after_reset");
    endtask

    task automatic test_random;
        logic [3:0]  r;
        logic [11:0] l;
        for (int p = 0; p < 4; p++) begin
            r = 4'($urandom_range(0, 15));
            l = 12'($urandom_range(1, 4095));
            launch(r, l);
            collect(30, 0, 800);
            test_packet_totals("random");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_zero_length();
        test_ignore_start();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
